// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and default sizes for the UART transmit FIFO slice.
package uart_tx_fifo_pkg;

  localparam int DEF_DATA_SIZE    = 8;
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_fifo_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-facing bundle of uart_tx_fifo.
// UART_TX_FIFO_LEVEL_EN adds the occupancy signal 'level'.
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int DEPTH     = DEF_DEPTH
) ();
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_SIZE-1:0] wr_data;
  logic                 wr_en;
  logic                 full;
  logic                 empty;
  logic                 overflow;
  logic [DATA_SIZE-1:0] tx_p_data;
  logic                 tx_data_valid;
  logic                 tx_busy;
  logic                 tx_timeout;

`ifdef UART_TX_FIFO_LEVEL_EN
  logic [ADDR_W:0]      level;

  modport master (output wr_data, wr_en, tx_busy,
                  input  full, empty, overflow, tx_p_data, tx_data_valid, tx_timeout, level);
  modport slave  (input  wr_data, wr_en, tx_busy,
                  output full, empty, overflow, tx_p_data, tx_data_valid, tx_timeout, level);
`else
  modport master (output wr_data, wr_en, tx_busy,
                  input  full, empty, overflow, tx_p_data, tx_data_valid, tx_timeout);
  modport slave  (input  wr_data, wr_en, tx_busy,
                  output full, empty, overflow, tx_p_data, tx_data_valid, tx_timeout);
`endif

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// sync_fifo_mem: byte storage, wrapping pointers, occupancy count and
// registered full/empty flags. Writes to a full FIFO and reads from an empty
// one are ignored here, so callers may raise the enables unconditionally.
module sync_fifo_mem #(
  parameter  int DATA_SIZE = 8,
  parameter  int DEPTH     = 16,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_W:0]      count
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr, rd_ptr;
  logic                 wr_ok, rd_ok;
  logic [ADDR_W:0]      count_nxt;

  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this cycle's accepted write/read
  always_comb begin
    count_nxt = count;
    if (wr_ok && !rd_ok)      count_nxt = count + 1'b1;
    else if (!wr_ok && rd_ok) count_nxt = count - 1'b1;
  end

  // Storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, count and flags; power-of-two depth makes pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of the UART transmitter plus the issue
// FSM that strobes one byte at a time and paces on the transmitter's busy.
// A transmitter that never raises busy sets a sticky timeout flag and the
// byte is treated as consumed.
// UART_TX_FIFO_LEVEL_EN: exposes the registered occupancy on bus.level.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TW     = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(BUSY_TIMEOUT);

  tx_fifo_state_e       state, state_nxt;
  logic                 pop, to_hit, cnt_clr, cnt_step;
  logic [TW-1:0]        busy_cnt, cnt_inc;
  logic [DATA_SIZE-1:0] head;
  logic                 full, empty;
  logic [ADDR_W:0]      count;
  logic [DATA_SIZE-1:0] p_data_q;
  logic                 dv_q, ovf_q, to_q;

  sync_fifo_mem #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign cnt_inc = busy_cnt + 1'b1;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty) state_nxt = SEND;
      SEND:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy)            state_nxt = WAIT_DONE;
                 else if (cnt_inc == TO_LIM) state_nxt = IDLE;
      WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // FSM output decode: pop/strobe request and timeout-counter control
  always_comb begin
    pop      = 1'b0;
    to_hit   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_step = 1'b0;
    case (state)
      IDLE:      pop = !empty;
      SEND:      cnt_clr = 1'b1;
      WAIT_BUSY: if (!bus.tx_busy) begin
                   cnt_step = 1'b1;
                   to_hit   = (cnt_inc == TO_LIM);
                 end
      default:   ;
    endcase
  end

  // Registered outputs and timeout counter; p_data holds until the next pop
  always_ff @(posedge clk) begin
    if (rst) begin
      p_data_q <= '0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      busy_cnt <= '0;
    end else begin
      dv_q  <= pop;
      ovf_q <= bus.wr_en & full;
      if (pop)         p_data_q <= head;
      if (cnt_clr)     busy_cnt <= '0;
      else if (cnt_step) busy_cnt <= cnt_inc;
      if (to_hit)      to_q <= 1'b1;
    end
  end

  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.overflow      = ovf_q;
  assign bus.tx_p_data     = p_data_q;
  assign bus.tx_data_valid = dv_q;
  assign bus.tx_timeout    = to_q;

`ifdef UART_TX_FIFO_LEVEL_EN
  assign bus.level = count;
`else
  logic unused_count;
  assign unused_count = ^count;
`endif

endmodule
